cbus_ram_responder: RTL and testbench

CBUS_RAM_RESPONDER -- requirements
Module: cbus_ram_responder

---
 rtl/cbus_ram_responder_pkg.sv | 47 ++++
 rtl/cbus_ram_responder_strobe_ram.sv | 27 ++
 rtl/cbus_ram_responder.sv | 160 ++++++++++++++++
 tb/tb_cbus_ram_responder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cbus_ram_responder_pkg.sv
// Shared bus types and responder state encoding.
package cbus_ram_responder_pkg;

    // Transfer size: bytes per beat = 1 << size
    typedef enum logic [2:0] {
        MSIZE_1B = 3'd0,
        MSIZE_2B = 3'd1,
        MSIZE_4B = 3'd2,
        MSIZE_8B = 3'd3
    } msize_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1
    } cbus_burst_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        cbus_burst_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        BEAT = 2'd2
    } ram_state_t;

    // Byte increment between consecutive beats of a burst
    function automatic logic [63:0] beat_step(input msize_t sz, input cbus_burst_t b);
        if (b == BURST_INCR)
            return 64'd1 << sz;
        return 64'd0;
    endfunction

endpackage

// File: rtl/cbus_ram_responder_strobe_ram.sv
// Byte-lane strobed word RAM: synchronous write, registered read (read-first).
module strobe_ram #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wstrb,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [7:0][7:0] mem [DEPTH];

    // Lane-masked write and registered read of the same word
    always_ff @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < 8; l++) begin
                if (wstrb[l])
                    mem[addr][l] <= wdata[l*8 +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/cbus_ram_responder.sv
// CBUS slave backed by a byte-strobed RAM. Reads burst, writes are single beat.
// The RAM is addressed with the address of the beat about to be entered, so the
// registered read data lands exactly in the beat cycle and writes commit on the
// edge that enters the beat.
module cbus_ram_responder
    import cbus_ram_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
    parameter int          LATENCY     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  cbus_req_t  req,
    output cbus_resp_t resp,
    output logic       oob
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    ram_state_t  state_q, state_d;
    logic [63:0] addr_q;
    logic [7:0]  remain_q;
    logic [3:0]  wait_q;
    logic        wr_q;
    msize_t      size_q;
    cbus_burst_t burst_q;
    logic [7:0]  strobe_q;
    logic [63:0] data_q;
    logic        oob_q;

    logic        accept;
    logic        enter_beat;
    logic        last_beat;
    logic [63:0] nxt_addr;
    logic [63:0] word;
    logic        in_range;
    logic        wr_cur;
    logic [7:0]  strobe_cur;
    logic [63:0] data_cur;
    logic        ram_we;
    logic [63:0] ram_rdata;

    assign accept    = (state_q == IDLE) && req.valid;
    assign last_beat = wr_q || (remain_q == 8'd0);

    // Next state and the address of the beat being entered on this edge
    always_comb begin
        state_d    = state_q;
        enter_beat = 1'b0;
        nxt_addr   = addr_q;
        case (state_q)
            IDLE: begin
                if (req.valid) begin
                    nxt_addr = req.addr;
                    if (LATENCY == 0) begin
                        state_d    = BEAT;
                        enter_beat = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req.valid) begin
                    state_d = IDLE;
                end else if (wait_q == 4'd0) begin
                    state_d    = BEAT;
                    enter_beat = 1'b1;
                end
            end
            BEAT: begin
                // A completed last beat always drops to IDLE for one full cycle
                if (!req.valid || last_beat) begin
                    state_d = IDLE;
                end else begin
                    enter_beat = 1'b1;
                    nxt_addr   = addr_q + beat_step(size_q, burst_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Transfer attributes come straight from the request on the accepting edge
    always_comb begin
        wr_cur     = wr_q;
        strobe_cur = strobe_q;
        data_cur   = data_q;
        if (state_q == IDLE) begin
            wr_cur     = req.is_write;
            strobe_cur = req.strobe;
            data_cur   = req.data;
        end
    end

    // Word index of the entering beat; subtraction wraps modulo 2^64
    assign word     = (nxt_addr - BASE_ADDR) >> 3;
    assign in_range = word < 64'(DEPTH_WORDS);
    assign ram_we   = enter_beat && wr_cur && in_range && !rst;

    strobe_ram #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (word[AW-1:0]),
        .wstrb (strobe_cur),
        .wdata (data_cur),
        .rdata (ram_rdata)
    );

    // State, latched request fields, beat address and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= 64'd0;
            remain_q <= 8'd0;
            wait_q   <= 4'd0;
            wr_q     <= 1'b0;
            size_q   <= MSIZE_1B;
            burst_q  <= BURST_FIXED;
            strobe_q <= 8'd0;
            data_q   <= 64'd0;
            oob_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wr_q     <= req.is_write;
                size_q   <= req.size;
                burst_q  <= req.burst;
                strobe_q <= req.strobe;
                data_q   <= req.data;
                remain_q <= req.len;
                wait_q   <= 4'(LATENCY - 1);
            end else if (state_q == WAIT && wait_q != 4'd0) begin
                wait_q <= wait_q - 4'd1;
            end
            if (accept || enter_beat)
                addr_q <= nxt_addr;
            if (state_q == BEAT && enter_beat)
                remain_q <= remain_q - 8'd1;
            oob_q <= enter_beat && !in_range;
        end
    end

    // Response is idle-zero outside BEAT; write beats and OOB reads return 0
    always_comb begin
        resp       = '0;
        oob        = 1'b0;
        if (state_q == BEAT) begin
            resp.ready = 1'b1;
            resp.last  = last_beat;
            resp.data  = (wr_q || oob_q) ? 64'd0 : ram_rdata;
            oob        = oob_q;
        end
    end

endmodule

// File: tb/tb_cbus_ram_responder.sv
// Directed bench for cbus_ram_responder (LATENCY=1).
module tb_cbus_ram_responder;
    import cbus_ram_responder_pkg::*;

    localparam logic [63:0] BASE = 64'h8000_0000;

    logic       clk = 1'b0;
    logic       rst;
    cbus_req_t  req;
    cbus_resp_t resp;
    logic       oob;

    int checks = 0;
    int errors = 0;

    logic [63:0] bd [16];
    logic        bl [16];
    logic        bo [16];
    int          bn;
    int          blat;

    cbus_ram_responder #(
        .DEPTH_WORDS (4096),
        .BASE_ADDR   (BASE),
        .LATENCY     (1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .resp (resp),
        .oob  (oob)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Issue one transfer, collect its beats, then confirm the idle cycle after it
    task automatic xfer(input logic wr, input logic [63:0] addr, input msize_t sz,
                        input logic [7:0] len, input cbus_burst_t b,
                        input logic [7:0] strb, input logic [63:0] data);
        bit done;
        done = 0;
        bn   = 0;
        blat = 0;
        @(negedge clk);
        req.valid = 1'b1; req.is_write = wr; req.size = sz; req.addr = addr;
        req.len = len; req.burst = b; req.strobe = strb; req.data = data;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk);
            if (resp.ready) begin
                if (bn == 0) blat = cyc;
                if (bn < 16) begin
                    bd[bn] = resp.data; bl[bn] = resp.last; bo[bn] = oob;
                end
                bn++;
                if (resp.last) begin
                    req.valid = 1'b0;
                    done = 1;
                end
            end
        end
        if (!done) begin
            chk("xfer_timeout", 64'(done), 64'd1);
            req.valid = 1'b0;
        end
        @(negedge clk);
        chk("idle_after", 64'(resp.ready), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(resp.ready), 64'd0);
        chk("rst_last",  64'(resp.last),  64'd0);
        chk("rst_data",  resp.data,       64'd0);
        chk("rst_oob",   64'(oob),        64'd0);
        rst = 1'b0;

        // Full-word write: one beat, two cycles after accept
        xfer(1, BASE + 8, MSIZE_8B, 8'd3, BURST_INCR, 8'hFF, 64'h1122334455667788);
        chk("wr_beats", 64'(bn), 64'd1);
        chk("wr_lat",   64'(blat), 64'd2);
        chk("wr_last",  64'(bl[0]), 64'd1);
        chk("wr_data",  bd[0], 64'd0);
        xfer(0, BASE + 8, MSIZE_8B, 8'd0, BURST_INCR, 8'h00, 64'd0);
        chk("rd_word1", bd[0], 64'h1122334455667788);

        // Partial strobe keeps upper lanes
        xfer(1, BASE + 8, MSIZE_8B, 8'd0, BURST_INCR, 8'h0F, 64'hAAAAAAAA_BBBBBBBB);
        xfer(0, BASE + 8, MSIZE_8B, 8'd0, BURST_INCR, 8'h00, 64'd0);
        chk("rd_strobe", bd[0], 64'h11223344_BBBBBBBB);

        // Preload words 0..3 with their index
        for (int i = 0; i < 4; i++)
            xfer(1, BASE + 64'(8*i), MSIZE_8B, 8'd0, BURST_INCR, 8'hFF, 64'(i));

        // INCR burst of four words
        xfer(0, BASE, MSIZE_8B, 8'd3, BURST_INCR, 8'h00, 64'd0);
        chk("incr_beats", 64'(bn), 64'd4);
        chk("incr_lat",   64'(blat), 64'd2);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("incr_d%0d", i), bd[i], 64'(i));
            chk($sformatf("incr_l%0d", i), 64'(bl[i]), (i == 3) ? 64'd1 : 64'd0);
        end

        // FIXED burst repeats word 2
        xfer(0, BASE + 16, MSIZE_8B, 8'd2, BURST_FIXED, 8'h00, 64'd0);
        chk("fix_beats", 64'(bn), 64'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("fix_d%0d", i), bd[i], 64'd2);

        // 4-byte INCR: addresses +0,+4,+8,+12 -> words 0,0,1,1
        xfer(0, BASE, MSIZE_4B, 8'd3, BURST_INCR, 8'h00, 64'd0);
        chk("w4_d0", bd[0], 64'd0);
        chk("w4_d1", bd[1], 64'd0);
        chk("w4_d2", bd[2], 64'd1);
        chk("w4_d3", bd[3], 64'd1);

        // Back-to-back: valid held, address changed on the last-beat edge
        begin
            int n;
            n = 0;
            @(negedge clk);
            req.valid = 1'b1; req.is_write = 1'b0; req.size = MSIZE_8B;
            req.addr = BASE + 16; req.len = 8'd0; req.burst = BURST_INCR;
            for (int c = 0; c < 10 && !resp.ready; c++) @(negedge clk);
            chk("b2b_first_d", resp.data, 64'd2);
            chk("b2b_first_l", 64'(resp.last), 64'd1);
            req.addr = BASE + 24;
            @(negedge clk);
            chk("b2b_idle", 64'(resp.ready), 64'd0);
            @(negedge clk);
            chk("b2b_wait", 64'(resp.ready), 64'd0);
            @(negedge clk);
            chk("b2b_second_r", 64'(resp.ready), 64'd1);
            chk("b2b_second_d", resp.data, 64'd3);
            req.valid = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (resp.ready) n++;
            end
            chk("b2b_no_repeat", 64'(n), 64'd0);
        end

        // Out-of-range read below base and write just past the top
        xfer(0, 64'h7FFF_FFF8, MSIZE_8B, 8'd0, BURST_INCR, 8'h00, 64'd0);
        chk("oob_rd_beats", 64'(bn), 64'd1);
        chk("oob_rd_data",  bd[0], 64'd0);
        chk("oob_rd_oob",   64'(bo[0]), 64'd1);
        chk("oob_rd_last",  64'(bl[0]), 64'd1);
        chk("oob_clear",    64'(oob), 64'd0);
        xfer(1, BASE + 64'(4096*8), MSIZE_8B, 8'd0, BURST_INCR, 8'hFF, 64'hDEADBEEF_CAFEF00D);
        chk("oob_wr_oob", 64'(bo[0]), 64'd1);
        chk("oob_wr_beats", 64'(bn), 64'd1);
        xfer(0, BASE, MSIZE_8B, 8'd0, BURST_INCR, 8'h00, 64'd0);
        chk("oob_no_alias", bd[0], 64'd0);

        // Write abandoned during WAIT leaves memory untouched
        @(negedge clk);
        req.valid = 1'b1; req.is_write = 1'b1; req.addr = BASE + 24;
        req.strobe = 8'hFF; req.data = 64'h5555_5555_5555_5555; req.len = 8'd0;
        @(negedge clk);
        req.valid = 1'b0;
        @(negedge clk);
        chk("abort_ready", 64'(resp.ready), 64'd0);
        xfer(0, BASE + 24, MSIZE_8B, 8'd0, BURST_INCR, 8'h00, 64'd0);
        chk("abort_word3", bd[0], 64'd3);

        // Reset on the second beat of a four-beat read
        begin
            int n;
            n = 0;
            @(negedge clk);
            req.valid = 1'b1; req.is_write = 1'b0; req.addr = BASE;
            req.len = 8'd3; req.burst = BURST_INCR; req.size = MSIZE_8B;
            for (int c = 0; c < 10 && n < 2; c++) begin
                @(negedge clk);
                if (resp.ready) n++;
            end
            chk("mid_beats_seen", 64'(n), 64'd2);
            rst = 1'b1;
            @(negedge clk);
            chk("mid_rst_ready", 64'(resp.ready), 64'd0);
            chk("mid_rst_last",  64'(resp.last),  64'd0);
            chk("mid_rst_oob",   64'(oob),        64'd0);
            chk("mid_rst_state", 64'(dut.state_q), 64'(IDLE));
            rst = 1'b0;
            req.valid = 1'b0;
            @(negedge clk);
            chk("mid_post_ready", 64'(resp.ready), 64'd0);
        end
        xfer(0, BASE, MSIZE_8B, 8'd3, BURST_INCR, 8'h00, 64'd0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("keep_d%0d", i), bd[i], 64'(i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
